// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared word width, data-memory responder states and address helper
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Byte address to word index; upper bits beyond the array are dropped so accesses wrap.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr, input int depth);
        return (addr >> 2) & WORD_W'(depth - 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x WORD_W storage, synchronous write, asynchronous read
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] Address_i,
    input  logic [WORD_W-1:0] WriteData_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic [WORD_W-1:0] data_o,
    output logic              ack_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] data_q;
    logic              ack_q;
    logic              err_q;

    logic              req;
    logic              commit;
    logic              mem_we;
    logic [WORD_W-1:0] rd_data;

    assign req    = MemRead_i | MemWrite_i;
    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
    // A reset on the commit edge must suppress the store as well as the FSM update.
    assign mem_we = commit & wr_q & ~rst_i;

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .addr_i (idx_q),
        .wdata_i(wdata_q),
        .rdata_o(rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= MemWrite_i;
                        idx_q   <= IDX_W'(word_index(Address_i, DEPTH));
                        wdata_q <= WriteData_i;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= WAIT;
                        if ((Address_i[1:0] != 2'b00) || (MemRead_i && MemWrite_i)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!wr_q) begin
                            data_q <= rd_data;
                        end
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_o = ((state_q == IDLE) && req) || (state_q == WAIT);
    assign data_o  = data_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY 3 and 1)
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst3, rd3, wr3, ack3, stall3, err3;
    logic [31:0] addr3, wd3, dout3;
    logic        rst1, rd1, wr1, ack1, stall1, err1;
    logic [31:0] addr1, wd1, dout1;

    dmem_responder #(.DEPTH(32), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .Address_i(addr3), .WriteData_i(wd3),
        .MemRead_i(rd3), .MemWrite_i(wr3), .data_o(dout3), .ack_o(ack3),
        .stall_o(stall3), .err_o(err3)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .Address_i(addr1), .WriteData_i(wd1),
        .MemRead_i(rd1), .MemWrite_i(wr1), .data_o(dout1), .ack_o(ack1),
        .stall_o(stall1), .err_o(err1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and hold it until ack; returns stall count, ack delay, load data, ack cycle.
    task automatic access(input bit fast, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls, output int delay,
                          output logic [31:0] data, output int ack_cyc);
        bit done = 0;
        logic s, a;
        stalls = 0; delay = -1; data = 'x; ack_cyc = -1;
        if (fast) begin rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd; end
        else      begin rd3 = rd; wr3 = wr; addr3 = addr; wd3 = wd; end
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            s = fast ? stall1 : stall3;
            a = fast ? ack1 : ack3;
            if (a) begin
                delay   = k - 1;
                data    = fast ? dout1 : dout3;
                ack_cyc = cyc;
                check("stall_in_resp", {31'b0, s}, 32'd0);
                done = 1;
            end else if (s) begin
                stalls++;
            end
            sync();
        end
        if (fast) begin rd1 = 0; wr1 = 0; end
        else      begin rd3 = 0; wr3 = 0; end
        if (!done) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset3();
        rst3 = 1;
        sync();
        rst3 = 0;
    endtask

    // Start a store on the slow DUT and hit reset during cycle rst_k of the access.
    task automatic aborted_store(input int rst_k, input string tag);
        bit saw_ack = 0;
        wr3 = 1; rd3 = 0; addr3 = 32'h8; wd3 = 32'h1234;
        for (int k = 1; k <= rst_k; k++) begin
            if (k == rst_k) begin rst3 = 1; wr3 = 0; end
            @(negedge clk);
            if (ack3) saw_ack = 1;
            sync();
        end
        rst3 = 0;
        @(negedge clk);
        if (ack3) saw_ack = 1;
        check({tag, "_no_ack"}, {31'b0, saw_ack}, 32'd0);
        check({tag, "_data_cleared"}, dout3, 32'd0);
        check({tag, "_no_stall"}, {31'b0, stall3}, 32'd0);
        sync();
    endtask

    int st, dl, ca, cb;
    logic [31:0] d;

    initial begin
        rst3 = 1; rd3 = 0; wr3 = 0; addr3 = 0; wd3 = 0;
        rst1 = 1; rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
        sync(); sync();
        rst3 = 0; rst1 = 0;
        @(negedge clk);
        check("rst_ack", {31'b0, ack3}, 32'd0);
        check("rst_stall", {31'b0, stall3}, 32'd0);
        check("rst_err", {31'b0, err3}, 32'd0);
        check("rst_data", dout3, 32'd0);
        sync();

        // Store then load
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, st, dl, d, ca);
        check("t1_st_stalls", st, 4);
        check("t1_st_delay", dl, 4);
        check("t1_st_data_kept", d, 32'd0);
        access(0, 1, 0, 32'h10, 32'h0, st, dl, d, ca);
        check("t1_ld_stalls", st, 4);
        check("t1_ld_delay", dl, 4);
        check("t1_ld_data", d, 32'hDEADBEEF);

        // Back-to-back loads
        access(0, 0, 1, 32'h0, 32'd1, st, dl, d, ca);
        access(0, 0, 1, 32'h4, 32'd2, st, dl, d, ca);
        access(0, 1, 0, 32'h0, 32'h0, st, dl, d, ca);
        check("t2_ld0", d, 32'd1);
        access(0, 1, 0, 32'h4, 32'h0, st, dl, d, cb);
        check("t2_ld1", d, 32'd2);
        check("t2_ack_spacing", cb - ca, 5);
        @(negedge clk);
        check("t2_data_hold", dout3, 32'd2);
        sync();

        // Address wrap
        access(0, 0, 1, 32'h80, 32'h5A, st, dl, d, ca);
        access(0, 1, 0, 32'h0, 32'h0, st, dl, d, ca);
        check("t3_wrap_data", d, 32'h5A);
        check("t3_err", {31'b0, err3}, 32'd0);

        // Misaligned, then conflicting request
        access(0, 0, 1, 32'h10, 32'd7, st, dl, d, ca);
        access(0, 1, 0, 32'h13, 32'h0, st, dl, d, ca);
        check("t4_misaligned_data", d, 32'd7);
        check("t4_misaligned_err", {31'b0, err3}, 32'd1);
        sync(); sync();
        @(negedge clk);
        check("t4_err_sticky", {31'b0, err3}, 32'd1);
        sync();
        reset3();
        @(negedge clk);
        check("t4_err_rst", {31'b0, err3}, 32'd0);
        sync();
        access(0, 1, 1, 32'h20, 32'hC0FFEE, st, dl, d, ca);
        check("t4_conflict_err", {31'b0, err3}, 32'd1);
        check("t4_conflict_delay", dl, 4);
        reset3();
        access(0, 1, 0, 32'h20, 32'h0, st, dl, d, ca);
        check("t4_conflict_written", d, 32'hC0FFEE);
        check("t4_conflict_err_clr", {31'b0, err3}, 32'd0);

        // Reset mid-operation: second WAIT cycle, then on the commit edge
        access(0, 0, 1, 32'h8, 32'hAAAA, st, dl, d, ca);
        access(0, 1, 0, 32'h8, 32'h0, st, dl, d, ca);
        check("t5_pre_data", d, 32'hAAAA);
        aborted_store(3, "t5_wait2");
        access(0, 1, 0, 32'h8, 32'h0, st, dl, d, ca);
        check("t5_wait2_old", d, 32'hAAAA);
        aborted_store(4, "t5_commit");
        access(0, 1, 0, 32'h8, 32'h0, st, dl, d, ca);
        check("t5_commit_old", d, 32'hAAAA);

        // LATENCY=1
        access(1, 0, 1, 32'hC, 32'h99, st, dl, d, ca);
        check("t6_st_stalls", st, 2);
        check("t6_st_delay", dl, 2);
        access(1, 1, 0, 32'hC, 32'h0, st, dl, d, ca);
        check("t6_ld_stalls", st, 2);
        check("t6_ld_delay", dl, 2);
        check("t6_ld_data", d, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
